leaf_inject_arbiter: RTL and testbench

LEAF_INJECT_ARBITER -- requirements
Module: leaf_inject_arbiter

---
 rtl/leaf_inject_arbiter.sv | 135 +++++++++++++
 tb/tb_leaf_inject_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_inject_arbiter.sv
// Four-port round-robin burst arbiter feeding a registered router injection slot.
// Define LEAF_ARB_STATS_EN to add per-port forwarded-flit counters (stat_sel/stat_count).
module leaf_inject_arbiter #(
   parameter int DATA_W    = 16,
   parameter int BURST_MAX = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [4*DATA_W-1:0] ni_data_in,
   input  logic [3:0]          ni_valid_in,
   output logic [3:0]          ni_ready_out,
   output logic [DATA_W-1:0]   router_data_out,
   output logic                router_valid_out,
   input  logic                router_ready_in,
   output logic [3:0]          grant_out,
   output logic                drop_pulse
`ifdef LEAF_ARB_STATS_EN
   ,
   input  logic [1:0]          stat_sel,
   output logic [15:0]         stat_count
`endif
);

   typedef enum logic {IDLE, OWN} state_t;

   localparam logic [3:0] BMAX = 4'(BURST_MAX);

   state_t              state_q;
   logic [1:0]          own_q;
   logic [1:0]          rr_q;
   logic [3:0]          bcnt_q;
   logic                vld_q;
   logic [DATA_W-1:0]   data_q;
   logic                drop_q;

   logic [DATA_W-1:0]   flit;
   logic [5:0]          hdr;
   logic                slot_free;
   logic                acc;
   logic [3:0]          own_oh;
   logic [3:0]          others;
   logic [1:0]          nxt;
   logic [3:0]          bsum;

   // First requester at or after ptr, wrapping modulo 4.
   function automatic logic [1:0] pick(input logic [3:0] req,
                                       input logic [1:0] ptr);
      logic [1:0] r;
      logic [1:0] k;
      r = ptr;
      for (int i = 3; i >= 0; i--) begin
         k = ptr + 2'(i);
         if (req[k]) r = k;
      end
      return r;
   endfunction

   assign flit      = ni_data_in[own_q*DATA_W +: DATA_W];
   assign hdr       = flit[DATA_W-1 -: 6];
   assign slot_free = !vld_q || router_ready_in;
   assign own_oh    = 4'b0001 << own_q;
   assign others    = ni_valid_in & ~own_oh;
   assign nxt       = own_q + 2'd1;
   assign bsum      = (bcnt_q == BMAX) ? bcnt_q : bcnt_q + 4'd1;

   assign ni_ready_out = (state_q == OWN && slot_free) ? own_oh : 4'b0000;
   assign acc          = |(ni_valid_in & ni_ready_out);

   assign grant_out        = (state_q == OWN) ? own_oh : 4'b0000;
   assign router_data_out  = data_q;
   assign router_valid_out = vld_q;
   assign drop_pulse       = drop_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         own_q   <= 2'd0;
         rr_q    <= 2'd0;
         bcnt_q  <= 4'd0;
         vld_q   <= 1'b0;
         data_q  <= '0;
         drop_q  <= 1'b0;
      end else begin
         drop_q <= acc && (hdr == 6'd0);
         if (acc && hdr != 6'd0) begin
            vld_q  <= 1'b1;
            data_q <= flit;
         end else if (vld_q && router_ready_in) begin
            vld_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (|ni_valid_in) begin
                  state_q <= OWN;
                  own_q   <= pick(ni_valid_in, rr_q);
                  bcnt_q  <= 4'd0;
               end
            end
            OWN: begin
               // A stalled slot freezes ownership and burst state.
               if (slot_free) begin
                  if (!ni_valid_in[own_q]) begin
                     rr_q   <= nxt;
                     bcnt_q <= 4'd0;
                     if (|ni_valid_in) own_q <= pick(ni_valid_in, nxt);
                     else state_q <= IDLE;
                  end else if (bsum == BMAX && |others) begin
                     own_q  <= pick(others, nxt);
                     rr_q   <= nxt;
                     bcnt_q <= 4'd0;
                  end else begin
                     bcnt_q <= bsum;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef LEAF_ARB_STATS_EN
   logic [15:0] cnt_q [4];

   assign stat_count = cnt_q[stat_sel];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int p = 0; p < 4; p++) cnt_q[p] <= 16'd0;
      end else if (acc && hdr != 6'd0 && cnt_q[own_q] != 16'hFFFF) begin
         cnt_q[own_q] <= cnt_q[own_q] + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_leaf_inject_arbiter.sv
// Directed self-checking bench for leaf_inject_arbiter (DATA_W=16, BURST_MAX=4).
module tb_leaf_inject_arbiter;

   logic        clk;
   logic        reset;
   logic [63:0] ni_data_in;
   logic [3:0]  ni_valid_in;
   logic [3:0]  ni_ready_out;
   logic [15:0] router_data_out;
   logic        router_valid_out;
   logic        router_ready_in;
   logic [3:0]  grant_out;
   logic        drop_pulse;
`ifdef LEAF_ARB_STATS_EN
   logic [1:0]  stat_sel;
   logic [15:0] stat_count;
`endif

   leaf_inject_arbiter #(.DATA_W(16), .BURST_MAX(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .ni_data_in       (ni_data_in),
      .ni_valid_in      (ni_valid_in),
      .ni_ready_out     (ni_ready_out),
      .router_data_out  (router_data_out),
      .router_valid_out (router_valid_out),
      .router_ready_in  (router_ready_in),
      .grant_out        (grant_out),
      .drop_pulse       (drop_pulse)
`ifdef LEAF_ARB_STATS_EN
      ,
      .stat_sel         (stat_sel),
      .stat_count       (stat_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Each port sources flits {6'h10+p, seq}; seq advances on accept.
   logic [9:0]  seq [4];
   int          lim [4];
   logic [3:0]  ovr_en;
   logic [15:0] ovr [4];
   logic        dmode;
   logic [15:0] fwd [$];
   int          dcnt, vcnt, rbad;

   function automatic logic [15:0] mk(input int p, input logic [9:0] s);
      if (dmode && p == 2 && s == 10'd3) return {6'h00, s};
      return {6'(16 + p), s};
   endfunction

   always_comb begin
      ni_data_in  = '0;
      ni_valid_in = '0;
      for (int p = 0; p < 4; p++) begin
         ni_data_in[p*16 +: 16] = ovr_en[p] ? ovr[p] : mk(p, seq[p]);
         ni_valid_in[p]         = int'(seq[p]) < lim[p];
      end
   end

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int p = 0; p < 4; p++) seq[p] <= '0;
      end else begin
         for (int p = 0; p < 4; p++)
            if (ni_valid_in[p] && ni_ready_out[p]) seq[p] <= seq[p] + 10'd1;
      end
   end

   always @(posedge clk)
      if (reset && router_valid_out && router_ready_in)
         fwd.push_back(router_data_out);

   initial rbad = 0;
   always @(negedge clk or negedge reset) begin
      if (!reset) begin
         dcnt <= 0;
         vcnt <= 0;
      end else begin
         if (drop_pulse) dcnt <= dcnt + 1;
         if (router_valid_out) vcnt <= vcnt + 1;
         if ($countones(ni_ready_out) > 1) rbad <= rbad + 1;
      end
   end

   task automatic do_reset();
      reset = 1'b0;
      for (int p = 0; p < 4; p++) lim[p] = 0;
      ovr_en = 4'b0000;
      dmode = 1'b0;
      router_ready_in = 1'b1;
      repeat (2) @(negedge clk);
      fwd.delete();
      reset = 1'b1;
   endtask

   task automatic wait_fwd(input int n, input int budget);
      int c = 0;
      while (fwd.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      if (fwd.size() < n) chk("fwd_timeout", 64'(fwd.size()), 64'(n));
   endtask

   task automatic wait_valid(input int budget);
      int c = 0;
      while (!router_valid_out && c < budget) begin
         @(negedge clk);
         c++;
      end
      if (!router_valid_out) chk("valid_timeout", 0, 1);
   endtask

   initial begin
      int bad;
      int c;
      logic [15:0] e;
      for (int p = 0; p < 4; p++) ovr[p] = 16'h0;
`ifdef LEAF_ARB_STATS_EN
      stat_sel = 2'd0;
`endif
      do_reset();
      reset = 1'b0;
      #1;
      chk("rst_grant", 64'(grant_out), 0);
      chk("rst_valid", 64'(router_valid_out), 0);
      chk("rst_data", 64'(router_data_out), 0);
      chk("rst_ready", 64'(ni_ready_out), 0);
      chk("rst_drop", 64'(drop_pulse), 0);
      @(negedge clk);
      reset = 1'b1;

      // All four ports saturating: bursts of 4 in port order.
      for (int p = 0; p < 4; p++) lim[p] = 1000;
      wait_fwd(32, 300);
      for (int k = 0; k < 32 && k < fwd.size(); k++) begin
         e = {6'(16 + (k / 4) % 4), 10'((k / 16) * 4 + k % 4)};
         chk($sformatf("rr_flit%0d", k), 64'(fwd[k]), 64'(e));
      end

      // Only port2: uninterrupted stream past BURST_MAX.
      do_reset();
      lim[2] = 10;
      bad = 0;
      c = 0;
      while (fwd.size() < 10 && c < 100) begin
         @(negedge clk);
         c++;
         if (fwd.size() < 10 && c > 1 && grant_out != 4'b0100) bad++;
      end
      chk("p2_count", 64'(fwd.size()), 10);
      chk("p2_grant_bad", 64'(bad), 0);
      for (int k = 0; k < 10 && k < fwd.size(); k++)
         chk($sformatf("p2_flit%0d", k), 64'(fwd[k]), 64'({6'h12, 10'(k)}));

      // Backpressure holds the slot and the owner.
      do_reset();
      ovr_en[1] = 1'b1;
      ovr[1] = 16'h1A55;
      lim[1] = 1;
      router_ready_in = 1'b0;
      wait_valid(20);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("bp_data%0d", i), 64'(router_data_out), 64'h1A55);
         chk($sformatf("bp_ready%0d", i), 64'(ni_ready_out), 0);
         chk($sformatf("bp_grant%0d", i), 64'(grant_out), 64'b0010);
         @(negedge clk);
      end
      router_ready_in = 1'b1;
      repeat (5) @(negedge clk);
      chk("bp_count", 64'(fwd.size()), 1);
      if (fwd.size() > 0) chk("bp_flit", 64'(fwd[0]), 64'h1A55);
      chk("bp_valid_end", 64'(router_valid_out), 0);

      // Header-zero flit is discarded.
      do_reset();
      ovr_en[3] = 1'b1;
      ovr[3] = 16'h03FF;
      lim[3] = 1;
      repeat (8) @(negedge clk);
      chk("drop_pulses", 64'(dcnt), 1);
      chk("drop_valid_cycles", 64'(vcnt), 0);
      chk("drop_fwd", 64'(fwd.size()), 0);

      // Reset while owning port1 with a full slot.
      do_reset();
      lim[1] = 100;
      router_ready_in = 1'b0;
      wait_valid(20);
      chk("mid_grant", 64'(grant_out), 64'b0010);
      reset = 1'b0;
      #1;
      chk("mid_rst_grant", 64'(grant_out), 0);
      chk("mid_rst_valid", 64'(router_valid_out), 0);
      chk("mid_rst_data", 64'(router_data_out), 0);
      chk("mid_rst_ready", 64'(ni_ready_out), 0);
      chk("mid_rst_drop", 64'(drop_pulse), 0);
      fwd.delete();
      lim[0] = 100;
      router_ready_in = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      c = 0;
      while (grant_out == 4'b0000 && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk("post_rst_grant", 64'(grant_out), 64'b0001);
      wait_fwd(1, 20);
      if (fwd.size() > 0) chk("post_rst_flit", 64'(fwd[0]), 64'h4000);

`ifdef LEAF_ARB_STATS_EN
      do_reset();
      dmode = 1'b1;
      stat_sel = 2'd2;
      lim[2] = 6;
      repeat (20) @(negedge clk);
      chk("stat_count", 64'(stat_count), 5);
      chk("stat_drops", 64'(dcnt), 1);
`endif

      chk("ready_onehot", 64'(rbad), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
